// File: rtl/multi_port_lutram.sv
// multi_port_lutram: distributed-RAM table with one byte-masked write port,
// NUM_READ_PORT synchronous read ports, a per-entry valid bit, single-entry
// invalidate, flush-all and a scrub sequencer that zeroes every entry after
// reset and after each flush.
// Optional feature macro: LUTRAM_OUTPUT_REG_EN adds a second output register
// stage (2-cycle read latency); undefined gives 1-cycle latency.
//
// Handshake: ready_out high means the array is in READY and every request
// presented on a rising edge is taken in that cycle; requests seen while
// ready_out is low (scrubbing) are dropped. Reads have no backpressure.

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module multi_port_lutram #(
    parameter int    SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int    NUM_SET                    = 64,
    parameter int    SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int    NUM_READ_PORT              = 2,
    parameter int    WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter string CONFIG_MODE                = "WriteFirst"
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic                                                write_port_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]                           write_port_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    write_port_access_set_addr_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               write_port_data_in,
    input  logic                                                invalidate_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                    invalidate_set_addr_in,
    input  logic                                                flush_all_in,
    input  logic [NUM_READ_PORT-1:0]                            read_port_access_en_in,
    input  logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_in,
    output logic [NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_out,
    output logic [NUM_READ_PORT-1:0]                            read_port_valid_out,
    output logic                                                ready_out
);

    localparam int DW = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam int NRP = NUM_READ_PORT;
    localparam int BL = `BYTE_LEN_IN_BITS;
    localparam bit WRITE_FIRST = (CONFIG_MODE == "WriteFirst");
    localparam logic [AW-1:0] LAST_SET = AW'(NUM_SET - 1);

    typedef enum logic {SCRUB = 1'b0, READY = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         scrub_ptr_q, scrub_ptr_d;
    logic [NUM_SET-1:0]    valid_q, valid_d;
    logic [DW-1:0]         mem_q [NUM_SET];

    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [WRITE_MASK_LEN-1:0] mem_be;
    logic [DW-1:0]         mem_wdata;
    logic                  wr_hit;
    logic [DW-1:0]         wr_merged;

    logic [AW-1:0]         rd_addr [NRP];
    logic [DW-1:0]         rd_data_q [NRP];
    logic [DW-1:0]         rd_data_d [NRP];
    logic [NRP-1:0]        rd_valid_q, rd_valid_d;
    logic [DW-1:0]         out_data [NRP];
    logic [NRP-1:0]        out_valid;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_SET;
    endfunction

    // Scrub sequencer, write/invalidate/flush decode and next valid array.
    always_comb begin
        state_d     = state_q;
        scrub_ptr_d = scrub_ptr_q;
        valid_d     = valid_q;
        mem_we      = 1'b0;
        mem_waddr   = scrub_ptr_q;
        mem_be      = '0;
        mem_wdata   = '0;
        wr_hit      = 1'b0;
        case (state_q)
            SCRUB: begin
                mem_we = 1'b1;
                mem_be = '1;
                if (flush_all_in) begin
                    scrub_ptr_d = '0;
                    valid_d     = '0;
                end else if (scrub_ptr_q == LAST_SET) begin
                    scrub_ptr_d = '0;
                    state_d     = READY;
                end else begin
                    scrub_ptr_d = scrub_ptr_q + 1'b1;
                end
            end
            default: begin
                if (flush_all_in) begin
                    valid_d     = '0;
                    scrub_ptr_d = '0;
                    state_d     = SCRUB;
                end else begin
                    if (write_port_access_en_in && (|write_port_write_en_in)
                        && in_range(write_port_access_set_addr_in)) begin
                        mem_we    = 1'b1;
                        mem_be    = write_port_write_en_in;
                        mem_waddr = write_port_access_set_addr_in;
                        mem_wdata = write_port_data_in;
                        wr_hit    = 1'b1;
                        valid_d[write_port_access_set_addr_in] = 1'b1;
                    end
                    // Invalidate is applied after the write so it wins on a tie.
                    if (invalidate_en_in && in_range(invalidate_set_addr_in)) begin
                        valid_d[invalidate_set_addr_in] = 1'b0;
                    end
                end
            end
        endcase
    end

    // Post-write word at the write address, used for WriteFirst bypass.
    always_comb begin
        wr_merged = '0;
        for (int b = 0; b < WRITE_MASK_LEN; b++) begin
            wr_merged[b*BL +: BL] = write_port_write_en_in[b]
                ? write_port_data_in[b*BL +: BL]
                : mem_q[write_port_access_set_addr_in][b*BL +: BL];
        end
    end

    // Control state and valid bits, cleared asynchronously.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= SCRUB;
            scrub_ptr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            scrub_ptr_q <= scrub_ptr_d;
            valid_q     <= valid_d;
        end
    end

    // Storage array: byte-enabled write, no reset (the scrub zeroes it).
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_waddr][b*BL +: BL] <= mem_wdata[b*BL +: BL];
                end
            end
        end
    end

    // Per-port read decode including collision bypass.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            rd_addr[p]    = read_port_access_set_addr_in[p*AW +: AW];
            rd_data_d[p]  = rd_data_q[p];
            rd_valid_d[p] = 1'b0;
            if (state_q == SCRUB) begin
                rd_data_d[p] = '0;
            end else if (read_port_access_en_in[p]) begin
                if (!in_range(rd_addr[p])) begin
                    rd_data_d[p] = '0;
                end else if (WRITE_FIRST) begin
                    rd_data_d[p]  = (wr_hit && (rd_addr[p] == write_port_access_set_addr_in))
                                    ? wr_merged : mem_q[rd_addr[p]];
                    rd_valid_d[p] = valid_d[rd_addr[p]];
                end else begin
                    rd_data_d[p]  = mem_q[rd_addr[p]];
                    rd_valid_d[p] = valid_q[rd_addr[p]];
                end
            end
        end
    end

    // Read data/valid registers, cleared asynchronously.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int p = 0; p < NRP; p++) rd_data_q[p] <= '0;
            rd_valid_q <= '0;
        end else begin
            for (int p = 0; p < NRP; p++) rd_data_q[p] <= rd_data_d[p];
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef LUTRAM_OUTPUT_REG_EN
    logic [DW-1:0]  out_data_q [NRP];
    logic [NRP-1:0] out_valid_q;

    // Extra output stage: data and valid delayed together.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int p = 0; p < NRP; p++) out_data_q[p] <= '0;
            out_valid_q <= '0;
        end else begin
            for (int p = 0; p < NRP; p++) out_data_q[p] <= rd_data_q[p];
            out_valid_q <= rd_valid_q;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
`else
    assign out_data  = rd_data_q;
    assign out_valid = rd_valid_q;
`endif

    // Pack per-port results onto the flat output buses.
    always_comb begin
        read_port_data_out = '0;
        for (int p = 0; p < NRP; p++) begin
            read_port_data_out[p*DW +: DW] = out_data[p];
        end
    end

    assign read_port_valid_out = out_valid;
    assign ready_out           = (state_q == READY);

endmodule

// File: tb/tb_multi_port_lutram.sv
// Bench for multi_port_lutram: a WriteFirst and a ReadFirst instance share
// the same stimulus; a behavioural table model predicts both every cycle.
module tb_multi_port_lutram;

    localparam int DW  = 64;
    localparam int NS  = 64;
    localparam int AW  = 6;
    localparam int NRP = 2;
    localparam int ML  = 8;
`ifdef LUTRAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int EW = 2 * NRP * (DW + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              wr_en;
    logic [ML-1:0]     wr_mask;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              inv_en;
    logic [AW-1:0]     inv_addr;
    logic              flush;
    logic [NRP-1:0]    rd_en;
    logic [NRP*AW-1:0] rd_addr;

    logic [NRP*DW-1:0] wf_data, rf_data;
    logic [NRP-1:0]    wf_valid, rf_valid;
    logic              wf_ready, rf_ready;

    multi_port_lutram #(.CONFIG_MODE("WriteFirst")) dut_wf (
        .clk_in(clk), .reset_in(rst),
        .write_port_access_en_in(wr_en), .write_port_write_en_in(wr_mask),
        .write_port_access_set_addr_in(wr_addr), .write_port_data_in(wr_data),
        .invalidate_en_in(inv_en), .invalidate_set_addr_in(inv_addr),
        .flush_all_in(flush),
        .read_port_access_en_in(rd_en), .read_port_access_set_addr_in(rd_addr),
        .read_port_data_out(wf_data), .read_port_valid_out(wf_valid),
        .ready_out(wf_ready)
    );

    multi_port_lutram #(.CONFIG_MODE("ReadFirst")) dut_rf (
        .clk_in(clk), .reset_in(rst),
        .write_port_access_en_in(wr_en), .write_port_write_en_in(wr_mask),
        .write_port_access_set_addr_in(wr_addr), .write_port_data_in(wr_data),
        .invalidate_en_in(inv_en), .invalidate_set_addr_in(inv_addr),
        .flush_all_in(flush),
        .read_port_access_en_in(rd_en), .read_port_access_set_addr_in(rd_addr),
        .read_port_data_out(rf_data), .read_port_valid_out(rf_valid),
        .ready_out(rf_ready)
    );

    // ---------------- scoreboard / model ----------------
    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_mem [NS];
    logic          m_valid [NS];
    int            m_scrub_left;
    logic [DW-1:0] m_hold_wf [NRP];
    logic [DW-1:0] m_hold_rf [NRP];
    logic [EW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the table's behaviour, driven by the current inputs.
    // Pushes the expected first-stage read result onto exp_q.
    task automatic model_step();
        logic [DW-1:0]     old_mem [NS];
        logic              old_v [NS];
        logic [NRP-1:0]    ewv, erv;
        logic [NRP*DW-1:0] ewd, erd;
        int a;
        old_mem = m_mem;
        old_v   = m_valid;
        ewv = '0;
        erv = '0;
        if (m_scrub_left > 0) begin
            for (int p = 0; p < NRP; p++) begin
                m_hold_wf[p] = '0;
                m_hold_rf[p] = '0;
            end
            if (flush) begin
                m_scrub_left = NS;
                for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
            end else begin
                m_mem[NS - m_scrub_left] = '0;
                m_scrub_left--;
            end
        end else begin
            if (flush) begin
                m_scrub_left = NS;
                for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
            end else begin
                if (wr_en && wr_mask != '0) begin
                    for (int b = 0; b < ML; b++)
                        if (wr_mask[b]) m_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
                    m_valid[wr_addr] = 1'b1;
                end
                if (inv_en) m_valid[inv_addr] = 1'b0;
            end
            for (int p = 0; p < NRP; p++) begin
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    m_hold_wf[p] = m_mem[a];
                    ewv[p]       = m_valid[a];
                    m_hold_rf[p] = old_mem[a];
                    erv[p]       = old_v[a];
                end
            end
        end
        for (int p = 0; p < NRP; p++) begin
            ewd[p*DW +: DW] = m_hold_wf[p];
            erd[p*DW +: DW] = m_hold_rf[p];
        end
        exp_q.push_back({ewv, ewd, erv, erd});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wr_en = 1'b0; wr_mask = '0; wr_addr = '0; wr_data = '0;
        inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [ML-1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    endtask

    task automatic drive_read(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    // Apply current inputs for one edge and compare all outputs.
    task automatic cycle();
        logic [EW-1:0]     e;
        logic [NRP-1:0]    ewv, erv;
        logic [NRP*DW-1:0] ewd, erd;
        model_step();
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        erd = e[NRP*DW-1:0];
        erv = e[NRP*DW +: NRP];
        ewd = e[NRP*DW+NRP +: NRP*DW];
        ewv = e[2*NRP*DW+NRP +: NRP];
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("wf_rd%0d", p), {wf_valid[p], wf_data[p*DW +: DW]}, {ewv[p], ewd[p*DW +: DW]});
            check($sformatf("rf_rd%0d", p), {rf_valid[p], rf_data[p*DW +: DW]}, {erv[p], erd[p*DW +: DW]});
        end
        check("wf_ready", wf_ready, m_scrub_left == 0);
        check("rf_ready", rf_ready, m_scrub_left == 0);
    endtask

    // Idle edges so a read issued last cycle reaches the output stage.
    task automatic drain_lat();
        repeat (LAT - 1) begin
            drive_idle();
            cycle();
        end
    endtask

    // Assert reset (outputs must clear without a clock edge), then release.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        check("rst_wf_out", {wf_valid, wf_data, wf_ready}, '0);
        check("rst_rf_out", {rf_valid, rf_data, rf_ready}, '0);
        m_scrub_left = NS;
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            m_hold_wf[p] = '0;
            m_hold_rf[p] = '0;
        end
        exp_q.delete();
        repeat (LAT - 1) exp_q.push_back('0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Count edges until ready_out rises; scrub-time writes are thrown in.
    task automatic wait_ready(input string tag, input bit noisy);
        int n;
        n = 0;
        while (!wf_ready && n < 200) begin
            drive_idle();
            if (noisy) begin
                drive_write(AW'($urandom_range(0, NS - 1)), {$urandom, $urandom}, '1);
                drive_read(0, AW'($urandom_range(0, NS - 1)));
            end
            cycle();
            n++;
        end
        check(tag, 128'(n), 128'(NS));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        drive_idle();
        do_reset();
        wait_ready("ready_lat_reset", 1'b0);

        // Freshly scrubbed entry reads zero, invalid.
        drive_idle(); drive_read(0, 6'd5); drive_read(1, 6'd5); cycle(); drain_lat();
        check("scrub_e5", {wf_valid[0], wf_data[DW-1:0]}, '0);

        // Full write then read on port 1 only.
        drive_idle(); drive_write(6'd3, 64'h1122334455667788, 8'hFF); cycle();
        drive_idle(); drive_read(1, 6'd3); cycle(); drain_lat();
        check("wr_rd_p1", {wf_valid[1], wf_data[DW +: DW]}, {1'b1, 64'h1122334455667788});
        check("wr_rd_p0_off", wf_valid[0], 1'b0);

        // Partial write colliding with reads on both ports.
        drive_idle(); drive_write(6'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        drive_read(0, 6'd3); drive_read(1, 6'd3); cycle(); drain_lat();
        check("coll_wf_p0", {wf_valid[0], wf_data[DW-1:0]}, {1'b1, 64'h11223344AAAAAAAA});
        check("coll_wf_p1", {wf_valid[1], wf_data[DW +: DW]}, {1'b1, 64'h11223344AAAAAAAA});
        check("coll_rf_p0", {rf_valid[0], rf_data[DW-1:0]}, {1'b1, 64'h1122334455667788});

        // Write and invalidate on the same entry: data lands, entry invalid.
        drive_idle(); drive_write(6'd9, 64'hDEADBEEFCAFEF00D, 8'hFF);
        inv_en = 1'b1; inv_addr = 6'd9; cycle();
        drive_idle(); drive_read(0, 6'd9); cycle(); drain_lat();
        check("wr_inv_9", {wf_valid[0], wf_data[DW-1:0]}, {1'b0, 64'hDEADBEEFCAFEF00D});

        // Randomized traffic on a narrow address window to force collisions.
        for (int i = 0; i < 300; i++) begin
            drive_idle();
            if ($urandom_range(0, 1) == 1)
                drive_write(AW'($urandom_range(0, 7)), {$urandom, $urandom},
                            ($urandom_range(0, 5) == 0) ? ML'(0) : ML'($urandom));
            inv_en   = ($urandom_range(0, 3) == 0);
            inv_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 99) == 0);
            rd_en    = NRP'($urandom);
            rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            cycle();
        end
        if (!wf_ready) wait_ready("ready_lat_rand", 1'b0);

        // Flush after writing entries 0-7; writes during scrub are dropped.
        for (int a = 0; a < 8; a++) begin
            drive_idle(); drive_write(AW'(a), {$urandom, $urandom}, '1); cycle();
        end
        drive_idle(); flush = 1'b1; cycle();
        check("flush_ready_fall", wf_ready, 1'b0);
        wait_ready("ready_lat_flush", 1'b1);
        for (int a = 0; a < NS; a += 2) begin
            drive_idle(); drive_read(0, AW'(a)); drive_read(1, AW'(a + 1)); cycle();
        end
        drain_lat();
        check("flush_last", {wf_valid, wf_data}, '0);

        // Reset in the middle of a scrub (pointer at 20).
        drive_idle(); flush = 1'b1; cycle();
        repeat (20) begin drive_idle(); cycle(); end
        do_reset();
        wait_ready("ready_lat_midrst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
